// File: rtl/argmax_pkg.sv
// Shared defaults and FSM encodings for the argmax frame scheduler.
package argmax_pkg;

    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_SCORE_W     = 26;
    localparam int DEF_IDX_W       = 4;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/argmax_cmp.sv
// Signed strict greater-than; shared with the parallel max unit so
// tie and sign handling match exactly.
module argmax_cmp
    import argmax_pkg::*;
#(
    parameter int W = DEF_SCORE_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         a_gt_b
);

    assign a_gt_b = $signed(a) > $signed(b);

endmodule

// File: rtl/argmax_frame_scheduler.sv
// Collects one frame of class scores, scans them one per cycle and
// presents the argmax index and score on a valid/ready output.
module argmax_frame_scheduler
    import argmax_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int IDX_W       = DEF_IDX_W
) (
    input  logic               clk,
    input  logic               GlobalReset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SCORE_W-1:0] in_score,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_index,
    output logic [SCORE_W-1:0] out_score,
    output logic               busy
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    logic [1:0]         state;
    logic [IDX_W-1:0]   wr_ptr;
    logic [IDX_W-1:0]   scan_cnt;
    logic [IDX_W-1:0]   best_idx;
    logic [SCORE_W-1:0] best_score;
    logic [SCORE_W-1:0] score_buf [NUM_CLASSES];
    logic [SCORE_W-1:0] cand;
    logic               ready_en;
    logic               valid_q;
    logic               cand_gt;
    logic               accept;
    logic               take;

    assign cand      = score_buf[scan_cnt];
    assign in_ready  = ready_en && (state == ST_LOAD);
    assign accept    = in_valid && in_ready;
    assign take      = valid_q && out_ready;
    assign busy      = (state == ST_SCAN) || (state == ST_DONE);
    assign out_valid = valid_q;
    assign out_index = valid_q ? best_idx : '0;
    assign out_score = valid_q ? best_score : '0;

    argmax_cmp #(
        .W (SCORE_W)
    ) u_cmp (
        .a      (cand),
        .b      (best_score),
        .a_gt_b (cand_gt)
    );

    // Storage only; contents are don't-care after reset or flush.
    always_ff @(posedge clk) begin
        if (accept && !flush) begin
            score_buf[wr_ptr] <= in_score;
        end
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state      <= ST_LOAD;
            wr_ptr     <= '0;
            scan_cnt   <= '0;
            best_idx   <= '0;
            best_score <= '0;
            valid_q    <= 1'b0;
            ready_en   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                state    <= ST_LOAD;
                wr_ptr   <= '0;
                scan_cnt <= '0;
                valid_q  <= 1'b0;
            end else begin
                unique case (state)
                    ST_LOAD: begin
                        if (accept) begin
                            if (wr_ptr == LAST) begin
                                wr_ptr     <= '0;
                                best_idx   <= '0;
                                best_score <= score_buf[0];
                                scan_cnt   <= ONE;
                                state      <= ST_SCAN;
                            end else begin
                                wr_ptr <= wr_ptr + ONE;
                            end
                        end
                    end
                    ST_SCAN: begin
                        if (cand_gt) begin
                            best_idx   <= scan_cnt;
                            best_score <= cand;
                        end
                        if (scan_cnt == LAST) begin
                            scan_cnt <= '0;
                            state    <= ST_DONE;
                        end else begin
                            scan_cnt <= scan_cnt + ONE;
                        end
                    end
                    ST_DONE: begin
                        // First DONE cycle is the result setup slot.
                        if (take) begin
                            valid_q <= 1'b0;
                            state   <= ST_LOAD;
                        end else begin
                            valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_LOAD;
                    end
                endcase
            end
        end
    end

endmodule
